// File: rtl/microprocessor_pkg.sv
// Shared types and constants for the host-side microprocessor command sequencer.
package microprocessor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1100;

    localparam logic [7:0] DEFAULT_IDLE_ADDR = 8'h00;

endpackage

// File: rtl/microprocessor_command_sequencer.sv
// Issues one arithmetic request to the microprocessor, watches MICROADDRESS for
// start/completion, and returns the result (or a timeout abort) on a response port.
module microprocessor_command_sequencer
    import microprocessor_pkg::*;
#(
    parameter logic [7:0] IDLE_ADDR      = DEFAULT_IDLE_ADDR,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic       SYSTEM_CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [3:0] REQ_OPCODE,
    input  logic [7:0] REQ_A,
    input  logic [7:0] REQ_B,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_DATA,
    output logic       RSP_TIMEOUT,
    output logic [3:0] OPCODE,
    output logic [7:0] DATA_IN_A,
    output logic [7:0] DATA_IN_B,
    output logic       GO_BAR,
    input  logic [7:0] MICROADDRESS,
    input  logic [7:0] DATA_OUT,
    output logic       BUSY
);

    // The timer is compared one count early so the abort lands on the edge it reaches the limit.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    seq_state_t state;
    seq_state_t next_state;
    logic [7:0] timer;
    logic       in_flight;
    logic       timeout_hit;
    logic       start_seen;
    logic       done_seen;

    assign in_flight   = (state == ISSUE) || (state == RUN);
    assign timeout_hit = in_flight && (timer == TIMEOUT_LAST);
    assign start_seen  = (MICROADDRESS != IDLE_ADDR);
    assign done_seen   = (MICROADDRESS == IDLE_ADDR);

    always_ff @(posedge SYSTEM_CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Timeout wins over a start or completion seen on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout_hit) begin
                    next_state = RESP;
                end else if (start_seen) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (timeout_hit || done_seen) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = (state == IDLE) && RESET;
        GO_BAR    = (state != ISSUE);
        RSP_VALID = (state == RESP);
        BUSY      = in_flight;
    end

    // Operands only move on acceptance so they stay stable through the whole transaction.
    always_ff @(posedge SYSTEM_CLK) begin
        if (!RESET) begin
            timer       <= 8'h00;
            OPCODE      <= 4'h0;
            DATA_IN_A   <= 8'h00;
            DATA_IN_B   <= 8'h00;
            RSP_DATA    <= 8'h00;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        OPCODE    <= REQ_OPCODE;
                        DATA_IN_A <= REQ_A;
                        DATA_IN_B <= REQ_B;
                        timer     <= 8'h00;
                    end
                end
                ISSUE, RUN: begin
                    timer <= timer + 8'd1;
                    if (timeout_hit) begin
                        RSP_DATA    <= 8'h00;
                        RSP_TIMEOUT <= 1'b1;
                    end else if ((state == RUN) && done_seen) begin
                        RSP_DATA    <= DATA_OUT;
                        RSP_TIMEOUT <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/microprocessor_command_sequencer.md
# microprocessor_command_sequencer

- Host-side initiator for the programmable 8-bit microprocessor.
- Accepts arithmetic requests (opcode, A, B) on a valid/ready port and drives the microprocessor's OPCODE, DATA_IN_A, DATA_IN_B and active-low GO_BAR.
- Tracks MICROADDRESS to detect start and completion, captures DATA_OUT and returns it on a valid/ready response port.
- Sits between a test/host controller and the microprocessor, replacing hand-timed GO_BAR pulses.

## Interface
Parameters:
- IDLE_ADDR, 8'h00, microaddress the microprocessor rests at when not executing
- TIMEOUT_CYCLES, 255, max cycles from GO_BAR assertion to completion before abort (1..255)

Ports:
- SYSTEM_CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  sequencer can accept request
- REQ_OPCODE  in  4  operation code
- REQ_A  in  8  operand A
- REQ_B  in  8  operand B
- RSP_VALID  out  1  response present
- RSP_READY  in  1  consumer accepts response
- RSP_DATA  out  8  result byte (8'h00 on timeout)
- RSP_TIMEOUT  out  1  response is a timeout abort
- OPCODE  out  4  to microprocessor
- DATA_IN_A  out  8  to microprocessor
- DATA_IN_B  out  8  to microprocessor
- GO_BAR  out  1  active-low start to microprocessor
- MICROADDRESS  in  8  from microprocessor
- DATA_OUT  in  8  from microprocessor
- BUSY  out  1  high in ISSUE or RUN

## Operation
- States:
  - IDLE: REQ_READY=1. On REQ_VALID: latch opcode/A/B onto OPCODE/DATA_IN_A/DATA_IN_B, clear timer, go to ISSUE.
  - ISSUE: GO_BAR=0. When sampled MICROADDRESS != IDLE_ADDR, go to RUN.
  - RUN: GO_BAR=1. When sampled MICROADDRESS == IDLE_ADDR, register DATA_OUT into RSP_DATA, RSP_TIMEOUT=0, go to RESP.
  - RESP: RSP_VALID=1. On RSP_READY, go to IDLE.
- Timer:
  - 8-bit; increments every cycle in ISSUE and RUN.
  - On reaching TIMEOUT_CYCLES (in either state): RSP_DATA=8'h00, RSP_TIMEOUT=1, GO_BAR=1, go to RESP.
  - Timeout has priority over a same-cycle start or completion detect.
- Operand outputs:
  - OPCODE/DATA_IN_A/DATA_IN_B are stable from ISSUE through RESP.
  - They hold their last values in IDLE and change only on request acceptance.
- No opcode checking; unsupported opcodes are passed through and complete or time out normally.
- Reset values (any state, including mid-operation), effective on the next edge with RESET=0:
  - GO_BAR=1
  - REQ_READY=0 while RESET=0, then 1 (state IDLE)
  - RSP_VALID=0, RSP_TIMEOUT=0, BUSY=0
  - RSP_DATA=8'h00, OPCODE=4'h0, DATA_IN_A=8'h00, DATA_IN_B=8'h00
  - timer=0

## Timing
- Acceptance edge (REQ_VALID&&REQ_READY) is edge N. At N+1: GO_BAR=0, BUSY=1, operands valid.
- GO_BAR stays low until the edge after MICROADDRESS is first sampled != IDLE_ADDR.
  - Minimum low pulse: 1 cycle.
  - If MICROADDRESS already != IDLE_ADDR at N+1, GO_BAR returns high at N+2.
- Completion is detected on the first RUN edge with MICROADDRESS == IDLE_ADDR.
  - RSP_VALID and RSP_DATA are valid the following cycle.
  - DATA_OUT must be valid in that sampled cycle.
- RESP holds RSP_VALID/RSP_DATA/RSP_TIMEOUT stable until RSP_READY.
  - Leaving RESP returns to IDLE: REQ_READY=1 the next cycle, so there is no back-to-back bypass.
  - Minimum request-to-request spacing: 4 cycles.
- Timeout path: GO_BAR rises and RSP_VALID=1 on the same edge the timer reaches TIMEOUT_CYCLES.

## Structure
- Shared package `microprocessor_pkg`:
  - state enum (IDLE, ISSUE, RUN, RESP)
  - opcode constants: OP_ADD=4'b0011, OP_SUB=4'b0111, OP_MUL=4'b1100
  - default IDLE_ADDR=8'h00
- Single module; no sub-module. Timer and FSM are inline.

## Test plan
- ADD: request 4'b0011, A=8'h31, B=8'h05 against the real microprocessor+control store -> one GO_BAR low pulse; RSP_DATA=8'h36, RSP_TIMEOUT=0.
- SUB then MUL back to back, REQ_VALID held high:
  - 4'b0111 with 8'h31/8'h05 -> 8'h2C.
  - 4'b1100 with 8'h31/8'h05 -> 8'hF5.
  - Second request accepted only after first response handshake.
- Backpressure: ADD with RSP_READY low for 10 cycles -> RSP_VALID/RSP_DATA=8'h36 held stable; REQ_READY=0 throughout.
- Timeout, TIMEOUT_CYCLES=20, MICROADDRESS stuck at IDLE_ADDR -> GO_BAR low 20 cycles, then RSP_TIMEOUT=1, RSP_DATA=8'h00, GO_BAR=1.
- Reset mid-RUN during MUL, RESET low for 1 cycle -> next edge GO_BAR=1, BUSY=0, RSP_VALID=0; a subsequent ADD completes with 8'h36.
- Immediate start: model MICROADDRESS leaving IDLE_ADDR in the first ISSUE cycle -> GO_BAR low exactly 1 cycle; result still captured correctly.
